// File: rtl/hex_display_pkg.sv
// Shared types and glyph table for the hex display controller.
// Segments are ordered gfedcba and active-low.
package hex_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Load/Ready capture port of the hex display controller.
// The master offers Data with Load; the slave accepts when Ready=1.
interface hex_display_ctrl_if #(
    parameter int DIGITS = 8
);

    logic                  Load;
    logic [4*DIGITS-1:0]   Data;
    logic                  Ready;

    modport master (
        output Load,
        output Data,
        input  Ready
    );

    modport slave (
        input  Load,
        input  Data,
        output Ready
    );

endinterface

// File: rtl/hex7seg_dec.sv
// One hex nibble to an active-low 7-segment glyph.
// A set blank input forces every segment off.
module hex7seg_dec
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output seg_t       o_seg
);

    always_comb begin
        o_seg = GLYPH[i_nib];
        if (i_blank) o_seg = SEG_BLANK;
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller: tear-free capture, static or
// scanned drive, leading-zero blanking and per-digit blinking.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    hex_display_ctrl_if.slave     bus,
    input  logic                  Mode,
    input  logic                  Blank_lz,
    input  logic [DIGITS-1:0]     Blink_mask,
    output logic [7*DIGITS-1:0]   Seg_flat,
    output seg_t                  Scan_seg,
    output logic [DIGITS-1:0]     Scan_an
);

    localparam int PS_W = $clog2(SCAN_DIV);
    localparam int IX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [IX_W-1:0] IX_LAST = IX_W'(DIGITS - 1);
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_disp;
    logic                r_valid;
    logic                r_pending;
    logic                r_phase;
    logic [PS_W-1:0]     r_presc;
    logic [IX_W-1:0]     r_idx;
    logic [FR_W-1:0]     r_frame;

    logic                w_tick;
    logic                w_frame_end;
    logic                w_apply;
    logic                w_accept;
    logic [DIGITS-1:0]   w_blank;
    logic [3:0]          w_scan_nib;
    logic                w_scan_blank;

    assign w_tick      = (r_presc == PS_LAST);
    assign w_frame_end = w_tick && (r_idx == IX_LAST);
    // Ready is simply "nothing waiting", so capture and apply never collide
    assign bus.Ready   = ~r_pending;
    assign w_accept    = bus.Load && ~r_pending;
    assign w_apply     = r_pending && (~Mode || w_frame_end);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_valid   <= 1'b0;
            r_pending <= 1'b0;
            r_phase   <= 1'b0;
            r_presc   <= '0;
            r_idx     <= '0;
            r_frame   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_end) begin
                if (r_frame == FR_LAST) begin
                    r_frame <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
            if (w_apply) begin
                r_disp    <= r_shadow;
                r_valid   <= 1'b1;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_shadow  <= bus.Data;
                r_pending <= 1'b1;
            end
        end
    end

    // Walk from the top digit down, tracking whether everything above is zero
    always_comb begin
        logic hz;
        hz      = 1'b1;
        w_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hz = hz && (r_disp[4*i +: 4] == 4'h0);
            w_blank[i] = !r_valid
                      || (Blink_mask[i] && r_phase)
                      || (Blank_lz && (i != 0) && hz);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        hex7seg_dec u_dec (
            .i_nib   (r_disp[4*g +: 4]),
            .i_blank (w_blank[g]),
            .o_seg   (Seg_flat[7*g +: 7])
        );
    end

    always_comb begin
        w_scan_nib   = '0;
        w_scan_blank = 1'b1;
        Scan_an      = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IX_W'(i)) begin
                w_scan_nib   = r_disp[4*i +: 4];
                w_scan_blank = w_blank[i] || !Mode;
                if (Mode && r_valid) Scan_an[i] = 1'b0;
            end
        end
    end

    hex7seg_dec u_scan_dec (
        .i_nib   (w_scan_nib),
        .i_blank (w_scan_blank),
        .o_seg   (Scan_seg)
    );

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised scoreboard bench for hex_display_ctrl (4 digits, fast scan).
// A cycle-count reference model queues expected outputs; a monitor checks.
module tb_hex_display_ctrl;

    localparam int D  = 4;
    localparam int S  = 4;
    localparam int B  = 2;
    localparam int FR = S * D;

    typedef struct {
        logic        ready;
        logic [27:0] flat;
        logic [6:0]  sseg;
        logic [3:0]  san;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode  = 1'b0;
    logic        blz   = 1'b0;
    logic [3:0]  bmask = 4'b0;
    logic [27:0] flat;
    logic [6:0]  sseg;
    logic [3:0]  san;

    hex_display_ctrl_if #(.DIGITS(D)) bus ();

    hex_display_ctrl #(
        .DIGITS       (D),
        .SCAN_DIV     (S),
        .BLINK_FRAMES (B)
    ) dut (
        .Clock      (clk),
        .Resetn     (rst_n),
        .bus        (bus),
        .Mode       (mode),
        .Blank_lz   (blz),
        .Blink_mask (bmask),
        .Seg_flat   (flat),
        .Scan_seg   (sseg),
        .Scan_an    (san)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      nm, act, exp_v, $time);
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reference model: all timing derived from edges since reset release
    int          m_n     = 0;
    bit          m_pend  = 0;
    bit          m_valid = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp   = '0;
    exp_t        q[$];

    function automatic exp_t expect_now();
        exp_t e;
        int   idx = (m_n / S) % D;
        bit   off = ((m_n / (FR * B)) % 2) == 1;
        e.ready = !m_pend;
        e.flat  = '0;
        e.sseg  = 7'h7F;
        for (int i = 0; i < D; i++) begin
            bit         bl;
            logic [6:0] sg;
            bl = !m_valid || (bmask[i] && off)
              || (blz && i > 0 && (m_disp >> (4 * i)) == 16'h0);
            sg = bl ? 7'h7F : glyph(m_disp[4*i +: 4]);
            e.flat[7*i +: 7] = sg;
            if (i == idx && mode) e.sseg = sg;
        end
        e.san = (mode && m_valid) ? ~(4'b0001 << idx) : 4'hF;
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n = 0; m_pend = 0; m_valid = 0;
            m_shadow = '0; m_disp = '0;
        end else begin
            if (m_pend && (!mode || ((m_n + 1) % FR) == 0)) begin
                m_disp = m_shadow; m_valid = 1; m_pend = 0;
            end else if (bus.Load && !m_pend) begin
                m_shadow = bus.Data; m_pend = 1;
            end
            m_n++;
        end
        q.push_back(expect_now());
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                chk("queue_empty", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                chk("ready",    {31'b0, bus.Ready}, {31'b0, e.ready});
                chk("seg_flat", {4'b0, flat},       {4'b0, e.flat});
                chk("scan_seg", {25'b0, sseg},      {25'b0, e.sseg});
                chk("scan_an",  {28'b0, san},       {28'b0, e.san});
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v);
        bus.Load = 1'b1; bus.Data = v;
        cyc(1);
        bus.Load = 1'b0;
    endtask

    initial begin
        bus.Load = 1'b0;
        bus.Data = '0;
        cyc(2); mode = 1'b1; cyc(2);
        rst_n = 1'b1; cyc(5);
        mode = 1'b0; cyc(3);

        bus.Load = 1'b1; bus.Data = 16'h12AF; cyc(1);
        bus.Data = 16'h5555; cyc(1);
        bus.Load = 1'b0; cyc(3);

        blz = 1'b1;
        load(16'h0030); cyc(2);
        load(16'h0000); cyc(2);
        load(16'h0500); cyc(2);
        for (int i = 0; i < 40; i++) begin
            bus.Load = 1'($urandom % 2);
            bus.Data = 16'($urandom);
            blz = 1'($urandom % 2);
            cyc(1);
        end
        bus.Load = 1'b0; blz = 1'b0; cyc(2);

        mode = 1'b1;
        load(16'h4321); cyc(40);
        cyc($urandom_range(1, 12));
        load(16'h8E9C); cyc(40);

        bmask = 4'b0001; cyc(150);

        for (int i = 0; i < 600; i++) begin
            if ($urandom % 32 == 0) mode = ~mode;
            if ($urandom % 50 == 0) bmask = 4'($urandom);
            if ($urandom % 40 == 0) blz = ~blz;
            bus.Load = ($urandom % 8 == 0);
            bus.Data = 16'($urandom);
            cyc(1);
        end
        bus.Load = 1'b0; mode = 1'b1; bmask = 4'b0;

        for (int i = 0; i < 40 && (m_pend || (m_n % FR) != 3); i++) cyc(1);
        load(16'hBEEF);
        rst_n = 1'b0;
        #1;
        chk("rst_flat",  {4'b0, flat},       {4'b0, 28'hFFFFFFF});
        chk("rst_ready", {31'b0, bus.Ready}, 32'd1);
        chk("rst_an",    {28'b0, san},       32'hF);
        chk("rst_seg",   {25'b0, sseg},      32'h7F);
        cyc(2);
        rst_n = 1'b1;
        cyc(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised multi-digit hexadecimal display controller for the board's 7-segment displays, replacing per-digit decoder instances wired straight to bus bits. It captures a data word through a Load/Ready handshake, applies it tear-free, and drives either all digits in parallel (static) or one digit at a time (scanned, shared segment lines). Leading-zero blanking and per-digit blinking are added. It sits between the processor's bus/debug nets and the HEX pins.

## Interface
- DIGITS, 8, number of hex digits (1..8); digit 0 is least significant
- SCAN_DIV, 50000, Clock cycles per scan tick (>=2)
- BLINK_FRAMES, 32, scan frames per blink half-period (>=1)
- Clock  in  1  single system clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- Load  in  1  request to capture Data; accepted only when Ready=1
- Data  in  4*DIGITS  value to display, nibble i -> digit i
- Ready  out  1  controller can accept a Load
- Mode  in  1  0 = static, 1 = scanned
- Blank_lz  in  1  blank leading zero digits
- Blink_mask  in  DIGITS  digit i blinks when bit i = 1
- Seg_flat  out  7*DIGITS  static segments, digit i at [7i+6:7i], active-low
- Scan_seg  out  7  scanned segment lines, active-low
- Scan_an  out  DIGITS  scanned digit enable, one-hot active-low

## Operation
- Registers: shadow (4*DIGITS), disp (4*DIGITS), valid, pending, prescaler, scan index, frame counter, blink phase.
- Handshake: Load=1 with Ready=1 at an edge -> shadow <= Data, pending <= 1, Ready <= 0. Load while Ready=0 ignored (no overwrite of shadow).
- Apply: static mode -> disp <= shadow on the next edge after capture; scanned mode -> at the next frame boundary. On apply: valid <= 1, pending <= 0, Ready <= 1.
- Prescaler counts 0..SCAN_DIV-1 in both modes; tick = terminal count. Index advances on tick, wraps DIGITS-1 -> 0; frame boundary = tick with index = DIGITS-1.
- Frame counter counts frame boundaries 0..BLINK_FRAMES-1; on wrap, blink phase toggles (0 = on, 1 = off).
- Per-digit visibility: blank if valid=0; else blank if Blink_mask[i] and phase=1; else blank if Blank_lz and digit i and all higher digits are 0, except digit 0 never lz-blanked.
- Blank code 7'b1111111; otherwise standard hex glyphs 0-F (same encoding as existing board decoder, e.g. 0 = 7'b1000000, F = 7'b0001110).
- Seg_flat: all digits, any mode. Scan_seg/Scan_an: valid only in Mode=1; in Mode=0 Scan_an = all 1, Scan_seg = blank.
- Mode 1 -> 0 with pending=1: apply on next edge. Mode 0 -> 1: scanning continues from current index, no counter reset.

## Timing
- Reset (async assert): Ready=1, valid=0, pending=0, disp=0, shadow=0, prescaler/index/frame=0, phase=0; Seg_flat all 1, Scan_seg=7'h7F, Scan_an=all 1 (no digit driven).
- Deassertion synchronised externally; first accepted Load at first edge after release.
- Static latency: Load at edge k -> Ready=0 after k -> disp/Seg_flat updated and Ready=1 after k+1. Max throughput one Load per 2 cycles.
- Scanned latency: capture to apply <= DIGITS*SCAN_DIV cycles; new value never appears mid-frame.
- Capture and frame boundary at same edge: capture only; apply at next boundary.
- Segment outputs combinational from registers (decoder after disp/index); Scan_an and Scan_seg change on the same edge.
- Reset mid-operation discards pending value; display returns to blank.

## Structure
- Package hex_display_pkg: SEG_BLANK constant, 16-entry glyph constants, seg_t (7-bit) typedef.
- One sub-module: hex7seg_dec (4-bit nibble + blank -> 7-bit active-low segments), instantiated DIGITS times for Seg_flat plus once for Scan_seg.
- Counters sized with $clog2 of their parameters.

## Test plan
Bench: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset, no Load -> Seg_flat = 28'hFFFFFFF, Ready=1, Scan_an=4'b1111 in both modes.
- Mode=0, Load Data=16'h12AF -> Ready low one cycle; next cycle digits = F,A,2,1 glyphs (0001110, 0001000, 0100100, 1111001); second Load while Ready=0 ignored.
- Mode=0, Blank_lz=1, Data=16'h0030 -> digits 3,2 blank, digit1 = 3 (0110000), digit0 = 0 (1000000); Data=16'h0000 -> only digit0 shows 0.
- Mode=1, Data=16'h4321 -> Scan_an steps 1110,1101,1011,0111 every 4 cycles with matching Scan_seg; Load mid-frame applied only after index 3 tick (<=16 cycles), Ready high then.
- Mode=1, Blink_mask=4'b0001 -> digit0 blank during alternating 2-frame windows (32 cycles on, 32 off), others steady.
- Assert Resetn low mid-pending in Mode=1 -> all outputs blank immediately, Ready=1, old value not applied after release.
